alu_result_buffer: RTL and testbench
====================================

ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 Parameter DEPTH, default 8, number of result entries (power of two).
REQ-002 Parameter IN_W, default 38, width of the ALU result word (ALU Output1).
REQ-003 Parameter OUT_W, default 32, width of the stored/saturated result.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_valid  input  1  ALU result on in_data is valid this cycle.
REQ-007 in_data  input  IN_W  signed two's-complement ALU result.
REQ-008 out_valid  output  1  head entry available.
REQ-009 out_ready  input  1  consumer accepts head entry this cycle.
REQ-010 out_data  output  OUT_W  saturated head result.
REQ-011 out_sat  output  1  head entry was saturated on entry.
REQ-012 full  output  1  count == DEPTH.
REQ-013 empty  output  1  count == 0.
REQ-014 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 overflow  output  1  sticky: a valid result was dropped.
REQ-016 clr_overflow  input  1  synchronous clear of overflow.

Function
REQ-017 pop SHALL equal out_valid && out_ready; push SHALL equal in_valid && (!full || pop).
REQ-018 On push, entry {sat, data} SHALL be written at wr_ptr and wr_ptr SHALL increment mod DEPTH.
REQ-019 On pop, rd_ptr SHALL increment mod DEPTH; out_data/out_sat SHALL reflect entry at rd_ptr (first-word fall-through).
REQ-020 Latency: a push in cycle N into an empty buffer SHALL give out_valid=1 with that data in cycle N+1; never in cycle N.
REQ-021 count SHALL update +1 on push-only, -1 on pop-only, unchanged on push+pop or neither.
REQ-022 Simultaneous push and pop when full SHALL be accepted; count stays DEPTH, no overflow.
REQ-023 Simultaneous push and pop when empty: push only (out_valid is 0, pop impossible).
REQ-024 Saturation: in_data > 2^(OUT_W-1)-1 -> data = 0x7FFFFFFF, sat=1.
REQ-025 Saturation: in_data < -2^(OUT_W-1) -> data = 0x80000000, sat=1.
REQ-026 Otherwise data = in_data[OUT_W-1:0], sat=0.
REQ-027 Drop: in_valid && full && !pop SHALL discard in_data, leave pointers/count unchanged, set overflow.
REQ-028 overflow SHALL clear on clr_overflow; a drop in the same cycle SHALL win (overflow=1).
REQ-029 out_data/out_sat SHALL be don't-care while out_valid=0; bench SHALL not check them then.

Reset
REQ-030 reset=0 SHALL immediately clear wr_ptr, rd_ptr, count, overflow, independent of clk.
REQ-031 During and after reset: out_valid=0, empty=1, full=0, count=0, overflow=0; storage contents need no reset.
REQ-032 Reset asserted mid-operation SHALL discard all stored entries; first push after release behaves as into an empty buffer.
REQ-033 Reset deassertion SHALL be taken synchronously to clk by the instantiating level; no push/pop in the release cycle is required to be accepted.

Structure
REQ-034 Shared package alu_pkg SHALL hold ALU_OUT_W=38, RES_W=32, RESBUF_DEPTH=8, SAT_MAX, SAT_MIN.
REQ-035 Saturation logic SHALL be a separate combinational sub-module sat_narrow (IN_W -> OUT_W, data + sat flag).
REQ-036 Storage SHALL be a register array indexed by log2(DEPTH)-bit pointers; count held as explicit register.

Verification
REQ-037 Reset, push in_data=1 once -> next cycle out_valid=1, out_data=1, out_sat=0, count=1.
REQ-038 Push 38'h0_8000_0000 (2^31) and 38'h3F_7FFF_FFFF (-2^31-1) -> out_data 0x7FFFFFFF/sat=1 then 0x80000000/sat=1.
REQ-039 Push 8 values with out_ready=0 -> full=1, count=8; 9th push -> dropped, overflow=1; drain yields original 8 in order.
REQ-040 Full buffer, in_valid=1 and out_ready=1 same cycle -> count stays 8, overflow stays 0, new value appears last on drain.
REQ-041 Overflow set, clr_overflow=1 with simultaneous drop -> overflow=1; clr_overflow alone next cycle -> overflow=0.
REQ-042 Push 5 entries, assert reset=0 asynchronously mid-cycle -> count=0, empty=1, out_valid=0 before next clk edge; after release, push 0x2 -> out_data=2.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU result-path constants: word widths, result buffer depth and saturation limits.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_OUT_W    = 38;
    localparam int RES_W        = 32;
    localparam int RESBUF_DEPTH = 8;

    // Most positive / most negative RES_W-bit two's-complement values.
    localparam logic [RES_W-1:0] SAT_MAX = {1'b0, {(RES_W-1){1'b1}}};
    localparam logic [RES_W-1:0] SAT_MIN = {1'b1, {(RES_W-1){1'b0}}};

endpackage

// File: rtl/sat_narrow.sv
// Signed saturating narrower: clamps an IN_W two's-complement word into OUT_W bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none (no handshake).
// Ports: in_data (IN_W, signed) -> out_data (OUT_W, clamped), sat (1 = value was clamped).
module sat_narrow
    import alu_pkg::*;
#(
    parameter int IN_W  = ALU_OUT_W,
    parameter int OUT_W = RES_W
) (
    input  logic [IN_W-1:0]  in_data,
    output logic [OUT_W-1:0] out_data,
    output logic             sat
);

    // The value fits in OUT_W bits exactly when every bit from the OUT_W sign
    // position upward is a copy of the IN_W sign bit.
    logic [IN_W-OUT_W:0] top_bits;
    logic                fits;

    assign top_bits = in_data[IN_W-1:OUT_W-1];
    assign fits     = (top_bits == '0) || (top_bits == '1);

    always_comb begin
        out_data = in_data[OUT_W-1:0];
        sat      = 1'b0;
        if (!fits) begin
            sat      = 1'b1;
            out_data = in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/alu_result_buffer.sv
// Result FIFO behind the ALU: saturates each result to OUT_W bits and queues it with a sat flag.
// Latency: push in cycle N is visible at the head (first-word fall-through) in cycle N+1.
// Backpressure: valid/ready on the output; when full, input is accepted only alongside a pop, otherwise dropped and overflow set (sticky).
// Ports: clk, reset (async active-low), in_valid/in_data, out_valid/out_ready/out_data/out_sat,
//        full, empty, count, overflow, clr_overflow.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH = RESBUF_DEPTH,
    parameter int IN_W  = ALU_OUT_W,
    parameter int OUT_W = RES_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_sat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Each entry is {sat, data}.
    logic [OUT_W:0]   mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             ovf;

    logic [OUT_W-1:0] nar_data;
    logic             nar_sat;
    logic             push;
    logic             pop;
    logic             drop;

    sat_narrow #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_sat_narrow (
        .in_data  (in_data),
        .out_data (nar_data),
        .sat      (nar_sat)
    );

    assign empty     = (cnt == '0);
    assign full      = (cnt == FULL_CNT);
    assign out_valid = !empty;
    assign count     = cnt;
    assign overflow  = ovf;

    // A pop frees the slot in the same cycle, so a full buffer still takes a push then.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    assign out_data = mem[rd_ptr][OUT_W-1:0];
    assign out_sat  = mem[rd_ptr][OUT_W];

    // Storage needs no reset; stale entries are never visible while count is 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {nar_sat, nar_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_overflow) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [37:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sat;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        overflow;
    logic        clr_overflow;

    int errors = 0;
    int checks = 0;

    alu_result_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sat      (out_sat),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [37:0] sv_in  [4];
        logic [31:0] sv_dat [4];
        logic        sv_sat [4];
        logic [31:0] drain2 [8];

        reset        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;

        // Reset state, before any clock edge.
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_empty",     empty,     1);
        chk("rst_full",      full,      0);
        chk("rst_count",     count,     0);
        chk("rst_overflow",  overflow,  0);

        tick();
        reset = 1'b1;
        tick();

        // Single push: visible next cycle, not the same cycle.
        in_valid = 1'b1;
        in_data  = 38'd1;
        #1;
        chk("lat_same_cycle_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("lat_valid", out_valid, 1);
        chk("lat_data",  out_data,  32'd1);
        chk("lat_sat",   out_sat,   0);
        chk("lat_count", count,     1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("lat_pop_empty", empty, 1);

        // Saturation patterns and in-range boundaries.
        sv_in[0] = 38'h00_8000_0000; sv_dat[0] = 32'h7FFF_FFFF; sv_sat[0] = 1'b1;
        sv_in[1] = 38'h3F_7FFF_FFFF; sv_dat[1] = 32'h8000_0000; sv_sat[1] = 1'b1;
        sv_in[2] = 38'h00_7FFF_FFFF; sv_dat[2] = 32'h7FFF_FFFF; sv_sat[2] = 1'b0;
        sv_in[3] = 38'h3F_FFFF_FFFB; sv_dat[3] = 32'hFFFF_FFFB; sv_sat[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = sv_in[i];
            tick();
        end
        in_valid = 1'b0;
        chk("sat_count", count, 4);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sat_data%0d", i), out_data, sv_dat[i]);
            chk($sformatf("sat_flag%0d", i), out_sat,  sv_sat[i]);
            tick();
        end
        out_ready = 1'b0;
        chk("sat_drained", empty, 1);

        // Fill to full, then drop a ninth value.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 38'(10 + i);
            tick();
        end
        chk("fill_full",     full,     1);
        chk("fill_count",    count,    8);
        chk("fill_overflow", overflow, 0);
        in_data = 38'd99;
        tick();
        chk("drop_overflow", overflow, 1);
        chk("drop_count",    count,    8);

        // Clear collides with another drop: drop wins; clear alone then works.
        clr_overflow = 1'b1;
        in_data      = 38'd98;
        tick();
        chk("clr_vs_drop", overflow, 1);
        in_valid = 1'b0;
        tick();
        clr_overflow = 1'b0;
        chk("clr_alone", overflow, 0);

        // Push and pop together while full.
        in_valid  = 1'b1;
        in_data   = 38'd55;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("fullpp_count",    count,    8);
        chk("fullpp_overflow", overflow, 0);
        chk("fullpp_full",     full,     1);

        // Drain: 11..17 in order, then the value pushed alongside the pop.
        for (int i = 0; i < 7; i++) drain2[i] = 32'(11 + i);
        drain2[7] = 32'd55;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_valid%0d", i), out_valid, 1);
            chk($sformatf("drain_data%0d", i),  out_data,  drain2[i]);
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", empty, 1);

        // Push and pop requested together while empty: push only.
        in_valid  = 1'b1;
        in_data   = 38'd77;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("emptypp_count", count,     1);
        chk("emptypp_valid", out_valid, 1);
        chk("emptypp_data",  out_data,  32'd77);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 38'(40 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("arst_pre_count", count, 5);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", count,     0);
        chk("arst_empty", empty,     1);
        chk("arst_valid", out_valid, 0);
        tick();
        reset = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = 38'd2;
        tick();
        in_valid = 1'b0;
        chk("arst_after_count", count,     1);
        chk("arst_after_valid", out_valid, 1);
        chk("arst_after_data",  out_data,  32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
